seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Decodes the multiplexed, active-low seven-segment scan bus (an_n anodes, seg_n cathodes in CA..CG order) back into hex nibbles.
- Assembles one nibble per digit into a full display word.
- Sits beside the display driver as a loopback checker and self-test monitor.
- Filters anode-transition ghosting with a stability counter and flags undecodable patterns per digit.

Parameters:
- N_DIGITS, 8, number of multiplexed digits; anode width, and value width = 4*N_DIGITS.
- STABLE_CYCLES, 4, consecutive identical registered samples required before a digit is captured; legal range 1..255.

Ports:
- clk  input  1  system clock, single domain.
- reset  input  1  synchronous, active-high reset.
- seg_n  input  7  cathodes; bit6=CA … bit0=CG; 0 = segment lit.
- an_n  input  N_DIGITS  anodes, active low; bit i = digit i (digit 0 = least-significant nibble).
- value  output  4*N_DIGITS  last complete decoded frame; nibble i = digit i.
- digit_err  output  N_DIGITS  per-digit flag for the last frame: the pattern was not in the decode table.
- frame_valid  output  1  one-cycle pulse when value and digit_err update.
- anode_err  output  1  sticky flag: more than one anode was low in a registered sample; clears on frame_valid or reset.

Behaviour:
- Input stage:
  - seg_n and an_n are registered once (sample regs) before use.
  - All logic below operates on the registered copies.
- Decode table (pattern -> nibble), all active low:
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3
  - 1001100->4, 0100100->5, 0100000->6, 0001111->7
  - 0000000->8, 0001100->9, 0001000->A, 1100000->B
  - 0110001->C, 1000010->D, 0110000->E, 0111000->F
  - Any other pattern, including 1111111 (blank), decodes to nibble 0 with err=1.
- Stability counter:
  - Increments while the registered {an_n, seg_n} equals the previous cycle's registered value.
  - Reloads to 1 on any change.
  - Saturates at STABLE_CYCLES.
- Capture:
  - Occurs on the single cycle the counter reaches STABLE_CYCLES while an_n is exactly one-hot-low, with index i.
  - Writes the decoded nibble and err into shadow slot i and sets captured_mask[i].
  - At most one capture per dwell: the counter stays saturated until the inputs change.
  - Re-capturing a slot that is already captured overwrites the slot; this is not an error.
- No-capture cases:
  - an_n all ones (blanking interval): no capture, counter runs normally.
  - More than one anode low: no capture, and anode_err is set.
- Frame commit:
  - On the cycle after captured_mask becomes all ones, shadow is copied to value/digit_err.
  - frame_valid pulses high for 1 cycle; captured_mask clears; anode_err clears.
  - If a capture coincides with the commit cycle, the commit uses the prior shadow and the new capture lands in the next frame's mask.
- Latency: an input change at edge k produces a capture at edge k+STABLE_CYCLES; frame_valid is high one cycle after the last digit's capture.
- Reset (synchronous, any time, including mid-frame):
  - value=0, digit_err=0, frame_valid=0, anode_err=0.
  - Shadow=0, captured_mask=0, counter=0, sample regs=all ones (blank).
  - A partial frame is discarded.

Optional Feature:
- Macro SEG_DP_EN.
- When defined:
  - Adds input dp_n (1 bit, active-low decimal point) and output dp (N_DIGITS).
  - dp_n is registered and included in the stability comparison.
  - dp_n is captured per digit alongside the nibble; dp[i]=1 when lit.
  - dp commits with frame_valid and resets to 0.
- When undefined: no dp ports exist, and behaviour is exactly as above.

Test Plan:
- Reset, then scan digits 0..7 showing patterns for 1,2,3,4,5,6,7,8 with dwell 10 cycles each -> single frame_valid pulse; value=32'h87654321; digit_err=0; anode_err=0.
- Dwell of STABLE_CYCLES-1 cycles on digit 3 between normal dwells -> digit 3 is not captured and no frame_valid pulse occurs until digit 3 gets a full dwell.
- Digit 5 driven 1111111 and digit 2 driven 1010101 in an otherwise valid frame -> frame_valid pulse; digit_err=8'b0010_0100; nibbles 5 and 2 = 0.
- Patterns 0100000 on digit 0 and 1100000 on digit 1 -> value[7:0]=8'hB6.
- an_n=8'b1111_0011 for 10 cycles mid-frame -> anode_err=1 with no capture; anode_err stays set until the next frame_valid, then clears.
- Assert reset after 5 digits have been captured, then run a full scan of A..F,0,1 -> exactly one frame_valid pulse; value=32'h10FEDCBA; no stale nibbles. With SEG_DP_EN defined and dp_n low on digit 7 -> dp=8'h80.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Loopback decoder for a multiplexed active-low 7-segment scan bus; rebuilds the displayed hex word.
// Optional decimal-point capture is compiled in with the SEG_DP_EN macro.
module seg_scan_decoder #(
  parameter int unsigned N_DIGITS      = 8,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_n,
  input  logic [N_DIGITS-1:0]     an_n,
`ifdef SEG_DP_EN
  input  logic                    dp_n,
  output logic [N_DIGITS-1:0]     dp,
`endif
  output logic [4*N_DIGITS-1:0]   value,
  output logic [N_DIGITS-1:0]     digit_err,
  output logic                    frame_valid,
  output logic                    anode_err
);

`ifdef SEG_DP_EN
  localparam int unsigned SampW = N_DIGITS + 8;
`else
  localparam int unsigned SampW = N_DIGITS + 7;
`endif
  localparam logic [7:0] CntMax = 8'(STABLE_CYCLES);

  // Returns {err, nibble}; anything outside the table decodes to 0 with err set.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'b0000001: res = 5'h00;
      7'b1001111: res = 5'h01;
      7'b0010010: res = 5'h02;
      7'b0000110: res = 5'h03;
      7'b1001100: res = 5'h04;
      7'b0100100: res = 5'h05;
      7'b0100000: res = 5'h06;
      7'b0001111: res = 5'h07;
      7'b0000000: res = 5'h08;
      7'b0001100: res = 5'h09;
      7'b0001000: res = 5'h0A;
      7'b1100000: res = 5'h0B;
      7'b0110001: res = 5'h0C;
      7'b1000010: res = 5'h0D;
      7'b0110000: res = 5'h0E;
      7'b0111000: res = 5'h0F;
      default:    res = 5'h10;
    endcase
    return res;
  endfunction

  logic [SampW-1:0]      samp_in, samp_q, prev_q;
  logic [7:0]            cnt_q, cnt_d;
  logic [4*N_DIGITS-1:0] shadow_q, shadow_d, value_q;
  logic [N_DIGITS-1:0]   shadow_err_q, shadow_err_d, digit_err_q;
  logic [N_DIGITS-1:0]   mask_q, mask_d;
  logic                  frame_valid_q, anode_err_q, anode_err_d;
  logic [N_DIGITS-1:0]   an_low;
  logic [6:0]            seg_s;
  logic [4:0]            dec;
  logic                  changed, reach, multi, one_hot, capture, commit;

`ifdef SEG_DP_EN
  logic [N_DIGITS-1:0]   shadow_dp_q, shadow_dp_d, dp_q;
  logic                  dp_s;
  assign samp_in = {dp_n, an_n, seg_n};
  assign dp_s    = samp_q[N_DIGITS+7];
  assign dp      = dp_q;
`else
  assign samp_in = {an_n, seg_n};
`endif

  assign seg_s   = samp_q[6:0];
  assign an_low  = ~samp_q[7 +: N_DIGITS];
  assign multi   = (an_low & (an_low - 1'b1)) != '0;
  assign one_hot = (an_low != '0) && !multi;
  assign changed = samp_q != prev_q;
  assign dec     = decode_seg(seg_s);
  assign commit  = &mask_q;

  always_comb begin
    cnt_d = cnt_q;
    if (changed) begin
      cnt_d = 8'd1;
    end else if (cnt_q < CntMax) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // A change that reloads straight to CntMax (STABLE_CYCLES == 1) also counts as reaching it.
  assign reach   = (cnt_d == CntMax) && (changed || (cnt_q != CntMax));
  assign capture = reach && one_hot;

  always_comb begin
    shadow_d     = shadow_q;
    shadow_err_d = shadow_err_q;
    mask_d       = commit ? '0 : mask_q;
`ifdef SEG_DP_EN
    shadow_dp_d  = shadow_dp_q;
`endif
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (capture && an_low[i]) begin
        shadow_d[4*i +: 4] = dec[3:0];
        shadow_err_d[i]    = dec[4];
        mask_d[i]          = 1'b1;
`ifdef SEG_DP_EN
        shadow_dp_d[i]     = ~dp_s;
`endif
      end
    end
  end

  always_comb begin
    anode_err_d = commit ? 1'b0 : anode_err_q;
    if (multi) begin
      anode_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      samp_q        <= '1;
      prev_q        <= '1;
      cnt_q         <= '0;
      shadow_q      <= '0;
      shadow_err_q  <= '0;
      mask_q        <= '0;
      value_q       <= '0;
      digit_err_q   <= '0;
      frame_valid_q <= 1'b0;
      anode_err_q   <= 1'b0;
`ifdef SEG_DP_EN
      shadow_dp_q   <= '0;
      dp_q          <= '0;
`endif
    end else begin
      samp_q        <= samp_in;
      prev_q        <= samp_q;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      shadow_err_q  <= shadow_err_d;
      mask_q        <= mask_d;
      frame_valid_q <= commit;
      anode_err_q   <= anode_err_d;
      if (commit) begin
        value_q     <= shadow_q;
        digit_err_q <= shadow_err_q;
      end
`ifdef SEG_DP_EN
      shadow_dp_q   <= shadow_dp_d;
      if (commit) begin
        dp_q        <= shadow_dp_q;
      end
`endif
    end
  end

  assign value       = value_q;
  assign digit_err   = digit_err_q;
  assign frame_valid = frame_valid_q;
  assign anode_err   = anode_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans hand-built frames and checks the committed words.
module tb_seg_scan_decoder;

  localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010, P3 = 7'b0000110;
  localparam logic [6:0] P4 = 7'b1001100, P5 = 7'b0100100, P6 = 7'b0100000, P7 = 7'b0001111;
  localparam logic [6:0] P8 = 7'b0000000, P9 = 7'b0001100, PA = 7'b0001000, PB = 7'b1100000;
  localparam logic [6:0] PC = 7'b0110001, PD = 7'b1000010, PE = 7'b0110000, PF = 7'b0111000;
  localparam logic [6:0] PBlank = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_n;
  logic [7:0]  an_n;
  logic        dp_n;
  logic [31:0] value;
  logic [7:0]  digit_err;
  logic        frame_valid;
  logic        anode_err;
`ifdef SEG_DP_EN
  logic [7:0]  dp;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  int          fv_count = 0;
  logic [31:0] fv_value = '0;
  logic [7:0]  fv_err   = '0;
  logic [7:0][6:0] pats;
  logic [7:0]  dps;

  always #5 clk = ~clk;

  seg_scan_decoder #(
    .N_DIGITS      (8),
    .STABLE_CYCLES (4)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .seg_n       (seg_n),
    .an_n        (an_n),
`ifdef SEG_DP_EN
    .dp_n        (dp_n),
    .dp          (dp),
`endif
    .value       (value),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .anode_err   (anode_err)
  );

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_count = fv_count + 1;
      fv_value = value;
      fv_err   = digit_err;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] an, input logic [6:0] seg, input logic dpn,
                       input int cycles);
    an_n  = an;
    seg_n = seg;
    dp_n  = dpn;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic scan_range(input int first, input int last, input int dwl);
    for (int i = first; i <= last; i++) begin
      drive(~(8'd1 << i), pats[i], dps[i], dwl);
    end
  endtask

  task automatic blank(input int cycles);
    drive(8'hFF, PBlank, 1'b1, cycles);
  endtask

  initial begin
    an_n  = 8'hFF;
    seg_n = PBlank;
    dp_n  = 1'b1;
    dps   = 8'hFF;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_value", value, 32'h0);
    check("rst_digit_err", {24'h0, digit_err}, 32'h0);
    check("rst_frame_valid", {31'h0, frame_valid}, 32'h0);
    check("rst_anode_err", {31'h0, anode_err}, 32'h0);
    reset = 1'b0;
    blank(3);

    // Frame 1..8 with an exact-latency look at the commit pulse
    pats[0] = P1; pats[1] = P2; pats[2] = P3; pats[3] = P4;
    pats[4] = P5; pats[5] = P6; pats[6] = P7; pats[7] = P8;
    fv_count = 0;
    scan_range(0, 6, 10);
    drive(8'b0111_1111, pats[7], 1'b1, 5);
    check("lat_fv_before", {31'h0, frame_valid}, 32'h0);
    @(negedge clk);
    check("lat_fv_pulse", {31'h0, frame_valid}, 32'h1);
    check("lat_value", value, 32'h87654321);
    @(negedge clk);
    check("lat_fv_after", {31'h0, frame_valid}, 32'h0);
    repeat (3) @(negedge clk);
    blank(3);
    check("f1_count", fv_count, 1);
    check("f1_value", fv_value, 32'h87654321);
    check("f1_err", {24'h0, fv_err}, 32'h0);
    check("f1_anode_err", {31'h0, anode_err}, 32'h0);

    // Short dwell on digit 3 must not capture
    pats[0] = P8; pats[1] = P7; pats[2] = P6; pats[3] = P5;
    pats[4] = P4; pats[5] = P3; pats[6] = P2; pats[7] = P1;
    fv_count = 0;
    scan_range(0, 2, 10);
    scan_range(3, 3, 3);
    scan_range(4, 7, 10);
    blank(3);
    check("short_no_frame", fv_count, 0);
    check("short_value_held", value, 32'h87654321);
    scan_range(3, 3, 10);
    blank(3);
    check("short_count", fv_count, 1);
    check("short_value", fv_value, 32'h12345678);

    // Undecodable patterns on digits 5 and 2
    pats[0] = P1; pats[1] = P2; pats[2] = 7'b1010101; pats[3] = P4;
    pats[4] = P5; pats[5] = PBlank; pats[6] = P7; pats[7] = P8;
    fv_count = 0;
    scan_range(0, 7, 10);
    blank(3);
    check("err_count", fv_count, 1);
    check("err_mask", {24'h0, fv_err}, 32'h24);
    check("err_value", fv_value, 32'h87054021);

    // B6 frame with a multi-anode dwell in the middle
    pats[0] = P6; pats[1] = PB;
    for (int i = 2; i < 8; i++) pats[i] = P0;
    fv_count = 0;
    scan_range(0, 3, 10);
    drive(8'b1111_0011, P9, 1'b1, 10);
    check("multi_anode_set", {31'h0, anode_err}, 32'h1);
    scan_range(4, 6, 10);
    check("multi_anode_sticky", {31'h0, anode_err}, 32'h1);
    check("multi_no_frame", fv_count, 0);
    scan_range(7, 7, 10);
    blank(3);
    check("b6_count", fv_count, 1);
    check("b6_low_byte", {24'h0, fv_value[7:0]}, 32'hB6);
    check("b6_value", fv_value, 32'h000000B6);
    check("multi_anode_clear", {31'h0, anode_err}, 32'h0);

    // Reset mid-frame discards the partial frame
    for (int i = 0; i < 8; i++) pats[i] = P9;
    scan_range(0, 4, 10);
    reset = 1'b1;
    blank(2);
    check("mid_rst_value", value, 32'h0);
    check("mid_rst_fv", {31'h0, frame_valid}, 32'h0);
    reset = 1'b0;
    pats[0] = PA; pats[1] = PB; pats[2] = PC; pats[3] = PD;
    pats[4] = PE; pats[5] = PF; pats[6] = P0; pats[7] = P1;
    dps = 8'b0111_1111;
    fv_count = 0;
    scan_range(5, 7, 10);
    blank(3);
    check("mid_rst_partial", fv_count, 0);
    scan_range(0, 4, 10);
    blank(3);
    check("mid_rst_count", fv_count, 1);
    check("mid_rst_frame", fv_value, 32'h10FEDCBA);
    check("mid_rst_err", {24'h0, fv_err}, 32'h0);
`ifdef SEG_DP_EN
    check("dp_digit7", {24'h0, dp}, 32'h80);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
